// File: rtl/multicycle_ctrl_if.sv
// Memory-side handshake bundle for the multi-cycle sequencer: instruction
// fetch request/ready plus IR strobe, and data memory request/ready/write.
interface multicycle_ctrl_if;
   logic imem_req;
   logic imem_ready;
   logic ir_we;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ready;

   modport master (
      output imem_req, ir_we, dmem_req, dmem_we,
      input  imem_ready, dmem_ready
   );

   modport slave (
      input  imem_req, ir_we, dmem_req, dmem_we,
      output imem_ready, dmem_ready
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 8-opcode 16-bit datapath. Steps one
// instruction at a time through FETCH/DECODE/EXEC/MEM/WB and decodes the
// datapath selects and strobes from the current state and opcode.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | imem request outstanding; IR loads on ready
// DECODE | one cycle for register reads
// EXEC   | ALU operation; beq retires here
// MEM    | dmem request outstanding; sw retires on ready
// WB     | register write-back; retires
// ERR    | memory timed out; left only by reset
module multicycle_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   multicycle_ctrl_if.master mem_if,
   input  logic              run_i,
   input  logic [2:0]        opcode_i,
   input  logic              eq_i,
   output logic              pc_we_o,
   output logic [1:0]        mux_pc_o,
   output logic [1:0]        func_alu_o,
   output logic              mux_alu1_o,
   output logic              mux_alu2_o,
   output logic              mux_rf_o,
   output logic [1:0]        mux_tgt_o,
   output logic              we_rf_o,
   output logic [2:0]        state_o,
   output logic              busy_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  instr_cnt_o
);
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // Last non-ready cycle that is still tolerated before giving up.
   localparam logic [WAIT_W-1:0] WAIT_TC = WAIT_W'(TIMEOUT - 1);

   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_LW   = 3'b100;
   localparam logic [2:0] OP_SW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic [1:0] alu_func;
   logic       alu_src1, alu_src2, rf_sel;
   logic       imem_req, ir_we, dmem_req, dmem_we;
   logic       retire;

   // Opcode-only decode of the ALU and register-read selects.
   always_comb begin
      alu_func = 2'b00;
      alu_src1 = 1'b0;
      alu_src2 = 1'b0;
      case (opcode_i)
         OP_NAND: alu_func = 2'b01;
         OP_LUI: begin
            alu_func = 2'b10;
            alu_src1 = 1'b1;
         end
         OP_ADDI, OP_LW, OP_SW: alu_src2 = 1'b1;
         default: ;
      endcase
      rf_sel = (opcode_i == OP_SW) || (opcode_i == OP_BEQ);
   end

   // Next state, wait/retire counters and all strobes/selects.
   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      retire     = 1'b0;
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      pc_we_o    = 1'b0;
      mux_pc_o   = 2'b00;
      func_alu_o = 2'b00;
      mux_alu1_o = 1'b0;
      mux_alu2_o = 1'b0;
      mux_rf_o   = 1'b0;
      mux_tgt_o  = 2'b00;
      we_rf_o    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run_i) begin
               state_d = S_FETCH;
               wait_d  = '0;
            end
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (mem_if.imem_ready) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end else if (wait_q == WAIT_TC) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_DECODE: begin
            mux_rf_o = rf_sel;
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            func_alu_o = alu_func;
            mux_alu1_o = alu_src1;
            mux_alu2_o = alu_src2;
            mux_rf_o   = rf_sel;
            if (opcode_i == OP_LW || opcode_i == OP_SW) begin
               state_d = S_MEM;
               wait_d  = '0;
            end else if (opcode_i == OP_BEQ) begin
               pc_we_o  = 1'b1;
               mux_pc_o = eq_i ? 2'b01 : 2'b00;
               retire   = 1'b1;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            func_alu_o = alu_func;
            mux_alu1_o = alu_src1;
            mux_alu2_o = alu_src2;
            mux_rf_o   = rf_sel;
            dmem_req   = 1'b1;
            dmem_we    = (opcode_i == OP_SW);
            if (mem_if.dmem_ready) begin
               if (opcode_i == OP_SW) begin
                  pc_we_o = 1'b1;
                  retire  = 1'b1;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_q == WAIT_TC) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_WB: begin
            func_alu_o = alu_func;
            mux_alu1_o = alu_src1;
            mux_alu2_o = alu_src2;
            mux_rf_o   = rf_sel;
            we_rf_o    = 1'b1;
            pc_we_o    = 1'b1;
            retire     = 1'b1;
            if (opcode_i == OP_LW) begin
               mux_tgt_o = 2'b00;
            end else if (opcode_i == OP_JALR) begin
               mux_tgt_o = 2'b10;
               mux_pc_o  = 2'b10;
            end else begin
               mux_tgt_o = 2'b01;
            end
         end
         S_ERR: ;
         default: state_d = S_IDLE;
      endcase
      // run is looked at only at the retire boundary.
      if (retire) begin
         cnt_d   = cnt_q + CNT_W'(1);
         state_d = run_i ? S_FETCH : S_IDLE;
         wait_d  = '0;
      end
   end

   // State, wait counter, retire counter and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign mem_if.imem_req = imem_req;
   assign mem_if.ir_we    = ir_we;
   assign mem_if.dmem_req = dmem_req;
   assign mem_if.dmem_we  = dmem_we;
   assign state_o         = state_q;
   assign busy_o          = (state_q != S_IDLE) && (state_q != S_ERR);
   assign err_o           = err_q;
   assign instr_cnt_o     = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a memory driver issues instructions with random
// wait states; a monitor tallies strobes per instruction and, at each retire,
// compares against the expectation pushed when the instruction was issued.
module tb_multicycle_ctrl;
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_ADDI = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_LUI  = 3'd3;
   localparam logic [2:0] OP_LW   = 3'd4;
   localparam logic [2:0] OP_SW   = 3'd5;
   localparam logic [2:0] OP_BEQ  = 3'd6;
   localparam logic [2:0] OP_JALR = 3'd7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run_i;
   logic [2:0]  opcode_i;
   logic        eq_i;
   logic        pc_we_o, mux_alu1_o, mux_alu2_o, mux_rf_o, we_rf_o, busy_o, err_o;
   logic [1:0]  mux_pc_o, func_alu_o, mux_tgt_o;
   logic [2:0]  state_o;
   logic [15:0] instr_cnt_o;

   multicycle_ctrl_if mif ();

   multicycle_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .mem_if(mif.master),
      .run_i(run_i), .opcode_i(opcode_i), .eq_i(eq_i),
      .pc_we_o(pc_we_o), .mux_pc_o(mux_pc_o), .func_alu_o(func_alu_o),
      .mux_alu1_o(mux_alu1_o), .mux_alu2_o(mux_alu2_o), .mux_rf_o(mux_rf_o),
      .mux_tgt_o(mux_tgt_o), .we_rf_o(we_rf_o), .state_o(state_o),
      .busy_o(busy_o), .err_o(err_o), .instr_cnt_o(instr_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      int          cycles, ireq, dreq, dwe, rfsel, werf;
      logic [1:0]  tgt, pc;
      logic [2:0]  rstate;
      logic [3:0]  alu;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e;
   int          checks = 0;
   int          failures = 0;
   bit          mon_en = 1'b0;
   logic [15:0] model_cnt = '0;

   int         c_cyc, c_ireq, c_irwe, c_dreq, c_dwe, c_rf, c_werf;
   logic [1:0] c_tgt;
   logic [3:0] c_alu_ex;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs_vec();
      return {11'd0, state_o, busy_o, err_o, pc_we_o, we_rf_o, mif.imem_req, mif.ir_we,
              mif.dmem_req, mif.dmem_we, mux_pc_o, func_alu_o, mux_alu1_o, mux_alu2_o,
              mux_rf_o, mux_tgt_o};
   endfunction

   // Reference: what one instruction should look like, from the opcode rules.
   function automatic exp_t model(input logic [2:0] op, input logic eq, input int wi,
                                  input int wd, input logic [15:0] cnt);
      exp_t r;
      bit is_mem = (op == OP_LW) || (op == OP_SW);
      bit has_wb = !((op == OP_BEQ) || (op == OP_SW));
      r.op     = op;
      r.cycles = (wi + 1) + 2 + (is_mem ? wd + 1 : 0) + (has_wb ? 1 : 0);
      r.ireq   = wi + 1;
      r.dreq   = is_mem ? wd + 1 : 0;
      r.dwe    = (op == OP_SW) ? wd + 1 : 0;
      r.rfsel  = (op == OP_SW) ? wd + 3 : (op == OP_BEQ) ? 2 : 0;
      r.werf   = has_wb ? 1 : 0;
      r.tgt    = !has_wb ? 2'd0 : (op == OP_LW) ? 2'd0 : (op == OP_JALR) ? 2'd2 : 2'd1;
      r.pc     = (op == OP_BEQ) ? {1'b0, eq} : (op == OP_JALR) ? 2'd2 : 2'd0;
      r.rstate = (op == OP_BEQ) ? 3'd3 : (op == OP_SW) ? 3'd4 : 3'd5;
      case (op)
         OP_NAND:              r.alu = 4'b0100;
         OP_LUI:               r.alu = 4'b1010;
         OP_ADDI, OP_LW, OP_SW: r.alu = 4'b0001;
         default:              r.alu = 4'b0000;
      endcase
      r.cnt = cnt;
      return r;
   endfunction

   // Monitor: tally one instruction's strobes, compare on its retire.
   always @(negedge clk) begin
      #2;
      if (!mon_en) begin
         c_cyc = 0; c_ireq = 0; c_irwe = 0; c_dreq = 0; c_dwe = 0; c_rf = 0; c_werf = 0;
         c_tgt = 2'd0; c_alu_ex = 4'd0;
      end else begin
         if (busy_o) c_cyc++;
         if (mif.imem_req) c_ireq++;
         if (mif.ir_we) c_irwe++;
         if (mif.dmem_req) c_dreq++;
         if (mif.dmem_we) c_dwe++;
         if (mux_rf_o) c_rf++;
         if (we_rf_o) begin
            c_werf++;
            c_tgt = mux_tgt_o;
         end
         if (state_o == 3'd3) c_alu_ex = {func_alu_o, mux_alu1_o, mux_alu2_o};
         if (pc_we_o) begin
            if (sb_q.size() == 0) begin
               check("unexpected_retire", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("cycles",      c_cyc,  e.cycles);
               check("imem_req_n",  c_ireq, e.ireq);
               check("ir_we_n",     c_irwe, 1);
               check("dmem_req_n",  c_dreq, e.dreq);
               check("dmem_we_n",   c_dwe,  e.dwe);
               check("mux_rf_n",    c_rf,   e.rfsel);
               check("we_rf_n",     c_werf, e.werf);
               check("mux_tgt",     {30'd0, c_tgt}, {30'd0, e.tgt});
               check("mux_pc",      {30'd0, mux_pc_o}, {30'd0, e.pc});
               check("retire_st",   {29'd0, state_o}, {29'd0, e.rstate});
               check("alu_exec",    {28'd0, c_alu_ex}, {28'd0, e.alu});
               check("alu_held",    {28'd0, func_alu_o, mux_alu1_o, mux_alu2_o}, {28'd0, e.alu});
               check("instr_cnt",   {16'd0, instr_cnt_o}, {16'd0, e.cnt});
            end
            c_cyc = 0; c_ireq = 0; c_irwe = 0; c_dreq = 0; c_dwe = 0; c_rf = 0; c_werf = 0;
            c_tgt = 2'd0; c_alu_ex = 4'd0;
         end
      end
   end

   // Drive one instruction: act as both memories until it retires.
   task automatic issue(input logic [2:0] op, input logic eq, input int wi, input int wd,
                        input bit drop_run);
      int  icnt = 0;
      int  dcnt = 0;
      int  n = 0;
      bit  done = 0;
      sb_q.push_back(model(op, eq, wi, wd, model_cnt));
      model_cnt++;
      @(negedge clk);
      opcode_i = op;
      eq_i     = eq;
      while (!done && n < 60) begin
         if (mif.imem_req) begin
            mif.imem_ready = (icnt == wi);
            icnt++;
         end else begin
            mif.imem_ready = 1'b0;
         end
         if (mif.dmem_req) begin
            if (drop_run) run_i = 1'b0;
            mif.dmem_ready = (dcnt == wd);
            dcnt++;
         end else begin
            mif.dmem_ready = 1'b0;
         end
         #1;
         if (pc_we_o) done = 1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      if (!done) check("issue_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int n;
      int fcyc;
      int seen;
      rst_n          = 1'b0;
      run_i          = 1'b0;
      opcode_i       = 3'd0;
      eq_i           = 1'b0;
      mif.imem_ready = 1'b0;
      mif.dmem_ready = 1'b0;
      #12;
      check("rst_outs", outs_vec(), 32'd0);
      check("rst_cnt", {16'd0, instr_cnt_o}, 32'd0);

      @(negedge clk);
      rst_n  = 1'b1;
      run_i  = 1'b1;
      mon_en = 1'b1;

      // Directed instruction mix, then random traffic.
      issue(OP_ADD,  1'b0, 0, 0, 0);
      issue(OP_BEQ,  1'b1, 0, 0, 0);
      issue(OP_BEQ,  1'b0, 0, 0, 0);
      issue(OP_LW,   1'b0, 0, 3, 0);
      issue(OP_SW,   1'b1, 1, 0, 0);
      issue(OP_JALR, 1'b0, 0, 0, 0);
      issue(OP_SW,   1'b0, 3, 3, 0);
      for (int i = 0; i < 150; i++)
         issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 3), 0);

      // run dropped during MEM of lw: lw completes, then IDLE.
      issue(OP_LW, 1'b0, 1, 2, 1);
      @(negedge clk);
      #2;
      check("rundrop_state", {29'd0, state_o}, 32'd0);
      check("rundrop_busy", {31'd0, busy_o}, 32'd0);
      check("rundrop_cnt", {16'd0, instr_cnt_o}, {16'd0, model_cnt});
      mon_en = 1'b0;
      check("sb_drain", sb_q.size(), 32'd0);
      // ready with no request outstanding is ignored.
      mif.imem_ready = 1'b1;
      mif.dmem_ready = 1'b1;
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         #2;
         if (state_o != 3'd0 || mif.imem_req) seen++;
      end
      check("idle_ignores_ready", seen, 32'd0);

      // Reset while in EXEC: immediate IDLE, counter cleared, no strobes.
      opcode_i = OP_ADD;
      run_i    = 1'b1;
      n = 0;
      while (state_o != 3'd3 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("reach_exec", {29'd0, state_o}, 32'd3);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_outs", outs_vec(), 32'd0);
      check("midrst_cnt", {16'd0, instr_cnt_o}, 32'd0);
      model_cnt = '0;

      // Fetch timeout: four non-ready FETCH cycles, then sticky ERR.
      mif.imem_ready = 1'b0;
      mif.dmem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      fcyc = 0;
      n = 0;
      while (state_o != 3'd6 && n < 20) begin
         @(negedge clk);
         #2;
         if (state_o == 3'd1) fcyc++;
         n++;
      end
      check("timeout_fetch_cycles", fcyc, 32'd4);
      check("err_state", {29'd0, state_o}, 32'd6);
      check("err_flag", {31'd0, err_o}, 32'd1);
      check("err_no_req", {31'd0, mif.imem_req}, 32'd0);
      check("err_busy", {31'd0, busy_o}, 32'd0);
      mif.imem_ready = 1'b1;
      repeat (5) @(negedge clk);
      #2;
      check("err_sticky", {28'd0, state_o, err_o}, {28'd0, 3'd6, 1'b1});
      rst_n = 1'b0;
      #1;
      check("err_cleared", {28'd0, state_o, err_o}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
